ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 192 +++++++++++++++++++
 tb/tb_ifetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into a 2-entry FIFO, and flush/restart on redirect.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   input  logic        i_inst_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_misaligned
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  drop_q, drop_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        mis_q;
   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_pc_q   [2];

   logic        req_s;
   logic        fire_s;
   logic        rsp_s;
   logic        push_s;
   logic        pop_s;
   logic        credit_ok_s;
   logic        redir_aligned_s;
   logic [31:0] rsp_pc_s;

   assign redir_aligned_s = (i_redirect_pc[1:0] == 2'b00);
   assign credit_ok_s     = (({1'b0, out_q} + {1'b0, count_q}) < 3'd2);
   assign fire_s          = req_s & i_imem_gnt;
   // A response with nothing outstanding is ignored rather than underflowing.
   assign rsp_s           = i_imem_rvalid & (out_q != 2'd0);
   assign push_s          = rsp_s & (drop_q == 2'd0) & ~i_redirect;
   assign pop_s           = (count_q != 2'd0) & i_inst_ready & ~i_redirect;
   // With no drops pending, every outstanding request is live, so the oldest
   // one was issued out_q words behind the fetch PC.
   assign rsp_pc_s        = fetch_pc_q - {28'd0, out_q, 2'b00};

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: any redirect decides RUN or HALT from target alignment
   always_comb begin
      state_d = state_q;
      if (i_redirect) begin
         if (redir_aligned_s) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_HALT;
         end
      end else begin
         state_d = state_q;
      end
   end

   // FSM outputs: request issue under the credit limit
   always_comb begin
      req_s = 1'b0;
      case (state_q)
         ST_RUN:  req_s = credit_ok_s & ~i_redirect & ~i_rst;
         ST_HALT: req_s = 1'b0;
         default: req_s = 1'b0;
      endcase
   end

   // Fetch PC, outstanding and drop counters
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      if (i_redirect) begin
         out_d  = out_q - {1'b0, rsp_s};
         drop_d = out_q - {1'b0, rsp_s};
         if (redir_aligned_s) begin
            fetch_pc_d = i_redirect_pc;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
      end else begin
         if (fire_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         case ({fire_s, rsp_s})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
         endcase
         if (rsp_s && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // FIFO pointer and occupancy next state
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_redirect) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q <= RESET_PC;
         out_q      <= 2'd0;
         drop_q     <= 2'd0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mis_q      <= i_redirect & ~redir_aligned_s;
      end
   end

   // FIFO storage, written only on push
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fifo_inst_q[0] <= 32'h0000_0000;
         fifo_inst_q[1] <= 32'h0000_0000;
         fifo_pc_q[0]   <= 32'h0000_0000;
         fifo_pc_q[1]   <= 32'h0000_0000;
      end else if (push_s) begin
         fifo_inst_q[wr_ptr_q] <= i_imem_rdata;
         fifo_pc_q[wr_ptr_q]   <= rsp_pc_s;
      end
   end

   assign o_imem_req   = req_s;
   assign o_imem_addr  = fetch_pc_q;
   assign o_inst_valid = (count_q != 2'd0);
   assign o_inst       = fifo_inst_q[rd_ptr_q];
   assign o_pc         = fifo_pc_q[rd_ptr_q];
   assign o_misaligned = mis_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized phase,
// checked against a queue-based model of issued requests and delivered words.
module tb_ifetch;

   localparam logic [31:0] OFF1 = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        d0_req, d0_valid, d0_mis;
   logic [31:0] d0_addr, d0_inst, d0_pc;
   logic        d1_req, d1_valid, d1_mis;
   logic [31:0] d1_addr, d1_inst, d1_pc;

   ifetch dut0 (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(d0_req), .o_imem_addr(d0_addr), .i_imem_gnt(imem_gnt),
      .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
      .o_inst_valid(d0_valid), .o_inst(d0_inst), .o_pc(d0_pc),
      .i_inst_ready(inst_ready), .i_redirect(redirect),
      .i_redirect_pc(redirect_pc), .o_misaligned(d0_mis)
   );

   ifetch #(.RESET_PC(OFF1)) dut1 (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(d1_req), .o_imem_addr(d1_addr), .i_imem_gnt(imem_gnt),
      .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
      .o_inst_valid(d1_valid), .o_inst(d1_inst), .o_pc(d1_pc),
      .i_inst_ready(inst_ready), .i_redirect(redirect),
      .i_redirect_pc(redirect_pc), .o_misaligned(d1_mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] addr; logic stale; } pend_t;
   typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;

   pend_t       pend[$];
   ent_t        fifo[$];
   logic [31:0] consumed0[$];
   logic [31:0] consumed1[$];
   logic [31:0] m_fetch;
   bit          m_run, m_mis, m_off;
   logic [31:0] key;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          first_gnt, first_val, mis_cnt, req_cnt;
   logic        obs_req;
   logic [31:0] obs_addr, obs_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ key;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      pend.delete(); fifo.delete();
      m_fetch = 32'h0; m_run = 1'b1; m_mis = 1'b0; m_off = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_d0_req",   32'(d0_req),   32'd0);
      chk("rst_d0_valid", 32'(d0_valid), 32'd0);
      chk("rst_d0_mis",   32'(d0_mis),   32'd0);
      chk("rst_d0_inst",  d0_inst,       32'h0);
      chk("rst_d0_pc",    d0_pc,         32'h0);
      chk("rst_d0_addr",  d0_addr,       32'h0);
      chk("rst_d1_req",   32'(d1_req),   32'd0);
      chk("rst_d1_valid", 32'(d1_valid), 32'd0);
      chk("rst_d1_pc",    d1_pc,         32'h0);
      chk("rst_d1_addr",  d1_addr,       OFF1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock of stimulus: drive, compare against the model, advance the model.
   task automatic step(input bit g, input bit rv, input bit rdy, input bit rd,
                       input logic [31:0] rpc);
      pend_t e;
      ent_t  f;
      bit    exp_req, do_rv, do_pop;
      @(negedge clk);
      do_rv = rv && (pend.size() > 0);
      imem_gnt    = g;
      imem_rvalid = do_rv;
      imem_rdata  = do_rv ? memf(pend[0].addr) : 32'h0;
      inst_ready  = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      exp_req = m_run && ((pend.size() + fifo.size()) < 2) && !rd;
      chk("req", 32'(d0_req), 32'(exp_req));
      if (exp_req) chk("addr", d0_addr, m_fetch);
      chk("valid", 32'(d0_valid), 32'(fifo.size() != 0));
      if (fifo.size() != 0) begin
         chk("inst", d0_inst, fifo[0].inst);
         chk("pc", d0_pc, fifo[0].pc);
      end
      chk("misaligned", 32'(d0_mis), 32'(m_mis));
      if (m_off) begin
         chk("d1_req", 32'(d1_req), 32'(exp_req));
         if (exp_req) chk("d1_addr", d1_addr, m_fetch + OFF1);
         if (fifo.size() != 0) chk("d1_pc", d1_pc, fifo[0].pc + OFF1);
      end
      obs_req = d0_req; obs_addr = d0_addr; obs_pc = d0_pc;
      if (d0_mis) mis_cnt++;
      if (d0_req) req_cnt++;
      if (exp_req && g && first_gnt < 0) first_gnt = cyc;
      if (d0_valid && first_val < 0) first_val = cyc;
      if (d0_valid && rdy && !rd) consumed0.push_back(d0_pc);
      if (d1_valid && rdy && !rd && m_off) consumed1.push_back(d1_pc);

      m_mis  = 1'b0;
      do_pop = (fifo.size() != 0) && rdy;
      if (rd) begin
         if (do_rv) void'(pend.pop_front());
         foreach (pend[i]) pend[i].stale = 1'b1;
         fifo.delete();
         m_off = 1'b0;
         if (rpc[1:0] == 2'b00) begin
            m_run = 1'b1; m_fetch = rpc;
         end else begin
            m_run = 1'b0; m_mis = 1'b1;
         end
      end else begin
         if (do_pop) void'(fifo.pop_front());
         if (do_rv) begin
            e = pend.pop_front();
            if (!e.stale) begin
               f.inst = memf(e.addr); f.pc = e.addr;
               fifo.push_back(f);
            end
         end
         if (exp_req && g) begin
            e.addr = m_fetch; e.stale = 1'b0;
            pend.push_back(e);
            m_fetch = m_fetch + 32'd4;
         end
      end
      cyc++;
   endtask

   initial begin
      bit          rg, rv, rr, rd;
      logic [31:0] rpc;
      key = $urandom;
      first_gnt = -1; first_val = -1;
      do_reset();

      // Full-throughput streaming after reset
      cyc = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_valid_latency", 32'(first_val - first_gnt), 32'd2);
      chk("seq0", consumed0[0], 32'h0000_0000);
      chk("seq1", consumed0[1], 32'h0000_0004);
      chk("seq2", consumed0[2], 32'h0000_0008);
      chk("wrap0", consumed1[0], 32'hFFFF_FFF8);
      chk("wrap1", consumed1[1], 32'hFFFF_FFFC);
      chk("wrap2", consumed1[2], 32'h0000_0000);

      // Decode stalled: FIFO fills, requests stop, head holds
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_req", 32'(obs_req), 32'd0);
      chk("stall_pc", obs_pc, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect with two requests in flight
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("inflight", 32'(pend.size()), 32'd2);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
      consumed0.delete();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("redir_pc", consumed0[0], 32'h0000_0100);

      // Misaligned redirect halts until an aligned one
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
      mis_cnt = 0; req_cnt = 0;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("mis_pulses", 32'(mis_cnt), 32'd1);
      chk("halt_reqs", 32'(req_cnt), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("resume_req", 32'(obs_req), 32'd1);
      chk("resume_addr", obs_addr, 32'h0000_0200);

      // Grant withheld: request and address hold
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         chk("nognt_req", 32'(obs_req), 32'd1);
         chk("nognt_addr", obs_addr, 32'h0);
      end

      // Randomized traffic with redirects and one mid-stream reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         rg  = ($urandom_range(0, 99) < 70);
         rv  = ($urandom_range(0, 99) < 60);
         rr  = ($urandom_range(0, 99) < 70);
         rd  = ($urandom_range(0, 99) < 4);
         rpc = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         step(rg, rv, rr, rd, rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
